// File: rtl/conv_pkg.sv
// Shared widths, the folded-result payload and the lane sign-extension helper
// for the conv partial-sum fold path.
package conv_pkg;

    localparam int unsigned CONV_TAPS = 9;
    localparam int unsigned CONV_DW   = 16;
    localparam int unsigned CONV_LN   = 3;
    localparam int unsigned CONV_AW   = 14;
    localparam int unsigned CONV_ACCW = 20;
    localparam int unsigned CONV_CW   = 4;

    // Payload carried by the output register slice: address in the low bits.
    typedef struct packed {
        logic [CONV_ACCW*CONV_LN-1:0] acc;
        logic [CONV_AW-1:0]           addr;
    } fold_res_t;

    // Pull lane `lane` out of a packed psum beat and sign-extend it to ACCW.
    function automatic logic [CONV_ACCW-1:0] lane_sext(
        input logic [CONV_DW*CONV_LN-1:0] v,
        input int unsigned                lane
    );
        logic [CONV_DW-1:0] x;
        x = v[CONV_DW*lane +: CONV_DW];
        return CONV_ACCW'($signed(x));
    endfunction

endpackage

// File: rtl/axi_frs.sv
// Forward register slice: registers data/valid, accepts a new beat when empty
// or when the held beat drains in the same cycle.
module axi_frs #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] m_data,
    input  logic          m_valid,
    output logic          m_ready,
    output logic [DW-1:0] s_data,
    output logic          s_valid,
    input  logic          s_ready
);

    assign m_ready = ~s_valid | s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (m_valid && m_ready) begin
            s_valid <= 1'b1;
            s_data  <= m_data;
        end else if (s_ready) begin
            s_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_psum_fold.sv
// Folds 9-tap partial-sum groups (or single non-fc beats) into one accumulated
// result per output address; result leaves through a forward register slice.
module conv_psum_fold
    import conv_pkg::*;
#(
    parameter int unsigned DW   = CONV_DW,
    parameter int unsigned LN   = CONV_LN,
    parameter int unsigned AW   = CONV_AW,
    parameter int unsigned ACCW = CONV_ACCW  // >= DW+4 so nine taps never wrap
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW*LN-1:0]   m_psum,
    input  logic [AW-1:0]      m_addr,
    input  logic               m_fc,
    input  logic               m_valid,
    output logic               m_ready,
    output logic [ACCW*LN-1:0] s_acc,
    output logic [AW-1:0]      s_addr,
    output logic               s_valid,
    input  logic               s_ready,
    output logic               err
);

    localparam int unsigned CW = CONV_CW;
    localparam int unsigned FW = ACCW*LN + AW;

    logic [CW-1:0]      cnt, cnt_nxt;
    logic [ACCW*LN-1:0] acc, acc_nxt, sum_c;
    logic [AW-1:0]      grp_addr, grp_addr_nxt, out_addr_c;
    logic               err_nxt;
    logic               final_c, hs_c, frs_ready, frs_valid;
    fold_res_t          frs_in, frs_out;

    // Running sum including the beat on the input; acc is zero at cnt=0.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < LN; i++) begin
            sum_c[ACCW*i +: ACCW] = acc[ACCW*i +: ACCW] + lane_sext(m_psum, i);
        end
    end

    assign final_c    = (cnt == CW'(CONV_TAPS - 1)) || ((cnt == '0) && !m_fc);
    assign m_ready    = final_c ? frs_ready : 1'b1;
    assign hs_c       = m_valid && m_ready;
    assign out_addr_c = (cnt == '0) ? m_addr : grp_addr;
    assign frs_valid  = m_valid && final_c;

    always_comb begin
        frs_in      = '0;
        frs_in.acc  = sum_c;
        frs_in.addr = out_addr_c;
    end

    // Tap counter, accumulator, group address and sticky error.
    always_comb begin
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        grp_addr_nxt = grp_addr;
        err_nxt      = err;
        if (hs_c) begin
            if ((cnt != '0) && ((m_addr != grp_addr) || !m_fc)) begin
                err_nxt = 1'b1;
            end
            if (final_c) begin
                cnt_nxt = '0;
                acc_nxt = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
                acc_nxt = sum_c;
                if (cnt == '0) begin
                    grp_addr_nxt = m_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            grp_addr <= '0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            grp_addr <= grp_addr_nxt;
            err      <= err_nxt;
        end
    end

    axi_frs #(
        .DW (FW)
    ) u_frs (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_data  (frs_in),
        .m_valid (frs_valid),
        .m_ready (frs_ready),
        .s_data  (frs_out),
        .s_valid (s_valid),
        .s_ready (s_ready)
    );

    assign s_acc  = frs_out.acc;
    assign s_addr = frs_out.addr;

endmodule

// File: tb/tb_conv_psum_fold.sv
// Randomized and directed checks of conv_psum_fold against a group-level
// reference model (list of accepted beats summed when the group closes).
module tb_conv_psum_fold;

    localparam int unsigned DW = 16, LN = 3, AW = 14, ACCW = 20;

    typedef struct { int p[3]; } beat_t;
    typedef struct { int acc[3]; logic [AW-1:0] addr; } res_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [DW*LN-1:0]   m_psum;
    logic [AW-1:0]      m_addr;
    logic               m_fc;
    logic               m_valid;
    logic               m_ready;
    logic [ACCW*LN-1:0] s_acc;
    logic [AW-1:0]      s_addr;
    logic               s_valid;
    logic               s_ready;
    logic               err;

    logic signed [DW-1:0] drv_p [3];

    assign m_psum = {drv_p[2], drv_p[1], drv_p[0]};

    conv_psum_fold dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_psum  (m_psum),
        .m_addr  (m_addr),
        .m_fc    (m_fc),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .s_acc   (s_acc),
        .s_addr  (s_addr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, srdy_pct = 100;
    int n_out = 0, n_stall = 0, last_out_cyc = 0, final_cyc = 0;
    int last_acc [3];
    logic [AW-1:0] last_addr;

    // Reference model state
    beat_t grp [$];
    res_t  exp_q [$];
    logic [AW-1:0] gaddr;
    bit merr;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        grp.delete();
        exp_q.delete();
        merr  = 1'b0;
        gaddr = '0;
    endfunction

    function automatic void model_accept();
        beat_t b;
        res_t  r;
        int    n;
        bit    closes;
        n = grp.size();
        if (n != 0 && (m_addr != gaddr || !m_fc)) merr = 1'b1;
        if (n == 0) gaddr = m_addr;
        for (int i = 0; i < 3; i++) b.p[i] = int'(drv_p[i]);
        grp.push_back(b);
        closes = (n == 0 && !m_fc) || (n == 8);
        if (closes) begin
            for (int i = 0; i < 3; i++) begin
                r.acc[i] = 0;
                foreach (grp[k]) r.acc[i] += grp[k].p[i];
            end
            r.addr = gaddr;
            exp_q.push_back(r);
            grp.delete();
            final_cyc = cyc;
        end
    endfunction

    // One clock: set s_ready, check outputs against the model, absorb handshakes.
    task automatic step(output bit acc_o);
        bit fin, exp_rdy;
        res_t e;
        int got;
        if ($urandom_range(99) < srdy_pct) s_ready = 1'b1;
        else s_ready = 1'b0;
        #1;
        fin     = (grp.size() == 8) || (grp.size() == 0 && !m_fc);
        exp_rdy = !fin || (exp_q.size() == 0) || s_ready;
        chk("s_valid", s_valid, exp_q.size() != 0);
        chk("m_ready", m_ready, exp_rdy);
        chk("err", err, merr);
        if (s_valid && s_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                got = $signed(s_acc[ACCW*i +: ACCW]);
                last_acc[i] = got;
                chk($sformatf("s_acc[%0d]", i), got, e.acc[i]);
            end
            chk("s_addr", s_addr, e.addr);
            last_addr    = s_addr;
            last_out_cyc = cyc;
            n_out++;
        end
        acc_o = m_valid && m_ready;
        if (acc_o) model_accept();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        m_valid = 1'b0;
        repeat (n) step(a);
    endtask

    task automatic send(input int p0, input int p1, input int p2,
                        input logic [AW-1:0] a, input bit f);
        bit ok;
        ok = 1'b0;
        drv_p[0] = DW'(p0);
        drv_p[1] = DW'(p1);
        drv_p[2] = DW'(p2);
        m_addr   = a;
        m_fc     = f;
        m_valid  = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            step(ok);
            if (!ok) n_stall++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        m_valid = 1'b0;
    endtask

    task automatic group9(input int v, input logic [AW-1:0] a);
        for (int k = 0; k < 9; k++) send(v, v, v, a, 1'b1);
    endtask

    task automatic pulse_reset();
        rst_n   = 1'b0;
        m_valid = 1'b0;
        #1;
        chk("rst_s_valid", s_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_s_acc", s_acc, 0);
        chk("rst_s_addr", s_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int out0, first_cyc, stalls0, v;
        bit ok;
        logic [AW-1:0] a;
        rst_n    = 1'b0;
        m_valid  = 1'b0;
        m_fc     = 1'b0;
        m_addr   = '0;
        s_ready  = 1'b0;
        drv_p[0] = '0;
        drv_p[1] = '0;
        drv_p[2] = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        pulse_reset();

        // Basic fold: 9 x 5 at 0x0040
        srdy_pct = 100;
        out0 = n_out;
        group9(5, 14'h0040);
        idle(3);
        chk("basic_nout", n_out - out0, 1);
        for (int i = 0; i < 3; i++) chk("basic_acc", last_acc[i], 45);
        chk("basic_addr", last_addr, 14'h0040);
        chk("basic_latency", last_out_cyc, final_cyc + 1);

        // Signed extremes
        for (int k = 0; k < 9; k++) send(-32768, 32767, (k % 2 == 0) ? 100 : -100, 14'h0123, 1'b1);
        idle(2);
        chk("signed_l0", last_acc[0], -294912);
        chk("signed_l1", last_acc[1], 294903);
        chk("signed_l2", last_acc[2], 100);

        // Pass-through, back to back
        out0 = n_out;
        for (int k = 1; k <= 4; k++) send(k, k, k, AW'(k), 1'b0);
        first_cyc = final_cyc - 3 + 1;
        idle(2);
        chk("pt_nout", n_out - out0, 4);
        chk("pt_back_to_back", last_out_cyc, first_cyc + 3);
        chk("pt_last_acc", last_acc[2], 4);
        chk("pt_last_addr", last_addr, 4);

        // Back-pressure: result A held while group B's last beat stalls
        srdy_pct = 0;
        out0 = n_out;
        group9(7, 14'h0010);
        for (int k = 0; k < 8; k++) send(3, 3, 3, 14'h0020, 1'b1);
        drv_p[0] = 16'sd3; drv_p[1] = 16'sd3; drv_p[2] = 16'sd3;
        m_addr = 14'h0020; m_fc = 1'b1; m_valid = 1'b1;
        step(ok); chk("bp_stall0", ok, 0);
        step(ok); chk("bp_stall1", ok, 0);
        srdy_pct = 100;
        step(ok); chk("bp_accept", ok, 1);
        chk("bp_first_acc", last_acc[0], 63);
        m_valid = 1'b0;
        idle(2);
        chk("bp_nout", n_out - out0, 2);
        chk("bp_second_acc", last_acc[1], 27);
        chk("bp_second_addr", last_addr, 14'h0020);

        // Protocol error: beat 5 address differs, group still completes
        for (int k = 0; k < 9; k++) send(k + 1, k + 1, -(k + 1), (k == 4) ? 14'h0041 : 14'h0040, 1'b1);
        idle(2);
        chk("perr_err", err, 1);
        chk("perr_sum", last_acc[0], 45);
        chk("perr_sum_neg", last_acc[2], -45);
        group9(1, 14'h0050);
        idle(1);
        chk("perr_sticky", err, 1);

        // Reset mid-group discards partial accumulation
        for (int k = 0; k < 4; k++) send(9, 9, 9, 14'h0060, 1'b1);
        pulse_reset();
        group9(2, 14'h0061);
        idle(2);
        for (int i = 0; i < 3; i++) chk("rmid_acc", last_acc[i], 18);
        chk("rmid_err", err, 0);

        // Randomized mix with back-pressure, gaps and occasional bad beats
        srdy_pct = 70;
        stalls0 = n_stall;
        for (int g = 0; g < 60; g++) begin
            a = AW'($urandom);
            if ($urandom_range(3) == 0) begin
                send($urandom_range(65535) - 32768, $urandom_range(65535) - 32768,
                     $urandom_range(65535) - 32768, a, 1'b0);
            end else begin
                for (int k = 0; k < 9; k++) begin
                    v = $urandom_range(65535) - 32768;
                    send(v, $urandom_range(65535) - 32768, -v,
                         ($urandom_range(29) == 0) ? AW'(a + 1) : a,
                         ($urandom_range(39) == 0) ? 1'b0 : 1'b1);
                    if ($urandom_range(4) == 0) idle($urandom_range(2));
                end
            end
        end
        srdy_pct = 100;
        idle(4);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_saw_stall", n_stall > stalls0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
